// File: rtl/alu_slice_seq.sv
// Bit-serialised ALU: a DWIDTH-bit op as DWIDTH/SLICE slices, LSB first, carry chained.
// Optional macro ALU_ROTATE_EN adds rol on opcode E; otherwise E is illegal.
module alu_slice_seq #(
  parameter int DWIDTH = 128,
  parameter int SLICE  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        opsel,
  input  logic              mode,
  input  logic [DWIDTH-1:0] op1,
  input  logic [DWIDTH-1:0] op2,
  input  logic              carry_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] result,
  output logic              c_flag,
  output logic              z_flag,
  output logic              o_flag,
  output logic              s_flag,
  output logic              illegal
);

  localparam int N  = DWIDTH / SLICE;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  localparam logic [3:0] OP_ADD = 4'h0, OP_SUBWB = 4'h1, OP_MOV = 4'h2, OP_SUB = 4'h3;
  localparam logic [3:0] OP_INC = 4'h4, OP_DEC = 4'h5, OP_ADDINC = 4'h6;
  localparam logic [3:0] OP_AND = 4'h8, OP_OR = 4'h9, OP_XOR = 4'hA, OP_NOT = 4'hB;
  localparam logic [3:0] OP_SHL = 4'hD, OP_ROL = 4'hE;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state_q, state_d;

  logic [DWIDTH-1:0] a_q, b_q;
  logic [3:0]        op_q;
  logic              carry_q, zacc_q;
  logic [IW-1:0]     idx_q;

  logic [SLICE-1:0]  a_s, b_s, x_s, slice_res;
  logic [SLICE:0]    sum, shift_t;
  logic              carry_nxt, is_arith, is_logic, is_shift, illegal_op, ovf_nxt;
  logic [3:0]        op_in;
  logic              carry_init;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign op_in     = {mode, opsel};

  // Carry seeded into slice 0: the +1 of sub/inc/addinc, or the rotated-in MSB.
  always_comb begin
    carry_init = 1'b0;
    case (op_in)
      OP_SUBWB:                 carry_init = carry_in;
      OP_SUB, OP_INC, OP_ADDINC: carry_init = 1'b1;
`ifdef ALU_ROTATE_EN
      OP_ROL:                   carry_init = op1[DWIDTH-1];
`endif
      default:                  carry_init = 1'b0;
    endcase
  end

  always_comb begin
    is_arith = (op_q[3] == 1'b0) && (op_q != 4'h7);
    is_logic = (op_q >= OP_AND) && (op_q <= OP_NOT);
`ifdef ALU_ROTATE_EN
    is_shift = (op_q == OP_SHL) || (op_q == OP_ROL);
`else
    is_shift = (op_q == OP_SHL);
`endif
    illegal_op = !(is_arith || is_logic || is_shift);
  end

  always_comb begin
    a_s = a_q[idx_q*SLICE +: SLICE];
    b_s = b_q[idx_q*SLICE +: SLICE];
    x_s = '0;
    case (op_q)
      OP_ADD, OP_ADDINC: x_s = b_s;
      OP_SUBWB, OP_SUB:  x_s = ~b_s;
      OP_DEC:            x_s = '1;
      default:           x_s = '0;
    endcase
    sum     = {1'b0, a_s} + {1'b0, x_s} + (SLICE+1)'(carry_q);
    shift_t = {a_s, carry_q};

    slice_res = '0;
    carry_nxt = 1'b0;
    ovf_nxt   = 1'b0;
    if (is_arith) begin
      slice_res = sum[SLICE-1:0];
      carry_nxt = sum[SLICE];
      ovf_nxt   = (a_s[SLICE-1] == x_s[SLICE-1]) && (sum[SLICE-1] != a_s[SLICE-1]);
    end else if (is_shift) begin
      slice_res = shift_t[SLICE-1:0];
      carry_nxt = shift_t[SLICE];
      ovf_nxt   = a_q[DWIDTH-1] ^ a_q[DWIDTH-2];
    end else if (is_logic) begin
      case (op_q)
        OP_AND:  slice_res = a_s & b_s;
        OP_OR:   slice_res = a_s | b_s;
        OP_XOR:  slice_res = a_s ^ b_s;
        default: slice_res = ~a_s;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = BUSY;
      BUSY:    if (idx_q == LAST) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      carry_q <= 1'b0;
      zacc_q  <= 1'b0;
      idx_q   <= '0;
      result  <= '0;
      c_flag  <= 1'b0;
      z_flag  <= 1'b0;
      o_flag  <= 1'b0;
      s_flag  <= 1'b0;
      illegal <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          a_q     <= op1;
          b_q     <= op2;
          op_q    <= op_in;
          carry_q <= carry_init;
          zacc_q  <= 1'b1;
          idx_q   <= '0;
        end
        BUSY: begin
          result[idx_q*SLICE +: SLICE] <= slice_res;
          carry_q <= carry_nxt;
          zacc_q  <= zacc_q & ~|slice_res;
          if (idx_q == LAST) begin
            c_flag  <= carry_nxt;
            z_flag  <= zacc_q & ~|slice_res;
            o_flag  <= ovf_nxt;
            s_flag  <= slice_res[SLICE-1];
            illegal <= illegal_op;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_slice_seq.sv
// Randomised and directed bench for alu_slice_seq (DWIDTH=128, SLICE=32) against a full-width arithmetic model.
module tb_alu_slice_seq;
  localparam int DW = 128;
  localparam int SL = 32;
  localparam int NS = DW / SL;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0, in_ready;
  logic [2:0]    opsel = '0;
  logic          mode = 1'b0;
  logic [DW-1:0] op1 = '0, op2 = '0;
  logic          carry_in = 1'b0;
  logic          out_valid, out_ready = 1'b0;
  logic [DW-1:0] result;
  logic          c_flag, z_flag, o_flag, s_flag, illegal;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [DW-1:0] res;
    logic          c, z, o, s, ill;
  } exp_t;

  exp_t last_obs;

  always #5 clk = ~clk;

  alu_slice_seq #(.DWIDTH(DW), .SLICE(SL)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .opsel(opsel), .mode(mode), .op1(op1), .op2(op2), .carry_in(carry_in),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .c_flag(c_flag), .z_flag(z_flag), .o_flag(o_flag), .s_flag(s_flag),
    .illegal(illegal)
  );

  // Reference: whole-width two's-complement arithmetic, no slicing.
  function automatic exp_t model(logic [3:0] op, logic [DW-1:0] a, logic [DW-1:0] b, logic ci);
    exp_t e;
    logic [DW:0]   w;
    logic [DW-1:0] x;
    logic          c0;
    e = '0; x = '0; c0 = 1'b0;
    case (op)
      4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6: begin
        case (op)
          4'h0: x = b;
          4'h1: begin x = ~b; c0 = ci; end
          4'h3: begin x = ~b; c0 = 1'b1; end
          4'h4: c0 = 1'b1;
          4'h5: x = '1;
          4'h6: begin x = b; c0 = 1'b1; end
          default: ;
        endcase
        w = {1'b0, a} + {1'b0, x} + {{DW{1'b0}}, c0};
        e.res = w[DW-1:0];
        e.c = w[DW];
        e.o = (op != 4'h2) && (a[DW-1] == x[DW-1]) && (e.res[DW-1] != a[DW-1]);
      end
      4'h8: e.res = a & b;
      4'h9: e.res = a | b;
      4'hA: e.res = a ^ b;
      4'hB: e.res = ~a;
      4'hD: begin e.res = a << 1; e.c = a[DW-1]; e.o = a[DW-1] ^ a[DW-2]; end
`ifdef ALU_ROTATE_EN
      4'hE: begin e.res = {a[DW-2:0], a[DW-1]}; e.c = a[DW-1]; e.o = a[DW-1] ^ a[DW-2]; end
`endif
      default: e.ill = 1'b1;
    endcase
    if (e.ill) e.z = 1'b1;
    else begin
      e.z = (e.res == '0);
      e.s = e.res[DW-1];
    end
    return e;
  endfunction

  task automatic chk(string tag, logic [DW+4:0] obs, logic [DW+4:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t observe();
    exp_t o;
    o.res = result; o.c = c_flag; o.z = z_flag; o.o = o_flag; o.s = s_flag; o.ill = illegal;
    return o;
  endfunction

  function automatic logic [DW-1:0] rnd_word();
    logic [DW-1:0] w;
    case ($urandom_range(0, 4))
      0:       w = '1;
      1:       w = {1'b0, {(DW-1){1'b1}}};
      2:       w = {1'b1, {(DW-1){1'b0}}};
      default: w = {$urandom, $urandom, $urandom, $urandom};
    endcase
    return w;
  endfunction

  // One full transaction: accept, latency, result, optional DONE hold with ignored request, handshake.
  task automatic run_op(string tag, logic [3:0] opc, logic [DW-1:0] a, logic [DW-1:0] b,
                        logic ci, int hold);
    exp_t e, held;
    int   cyc;
    logic busy_rdy;
    e = model(opc, a, b, ci);
    @(negedge clk);
    chk({tag, "_idle_rdy"}, (DW+5)'(in_ready), (DW+5)'(1));
    in_valid = 1'b1; {mode, opsel} = opc; op1 = a; op2 = b; carry_in = ci;
    @(posedge clk); #1;
    in_valid = 1'b0;
    op1 = rnd_word(); op2 = rnd_word(); {mode, opsel} = 4'($urandom); carry_in = 1'($urandom);
    cyc = 0; busy_rdy = 1'b0;
    while (!out_valid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      if (in_ready) busy_rdy = 1'b1;
    end
    chk({tag, "_latency"}, (DW+5)'(cyc), (DW+5)'(NS));
    chk({tag, "_busy_rdy"}, (DW+5)'(busy_rdy), (DW+5)'(0));
    last_obs = observe();
    chk({tag, "_out"}, last_obs, e);
    if (hold > 0) begin
      @(negedge clk);
      in_valid = 1'b1; {mode, opsel} = 4'h0; op1 = '1; op2 = '1;
      repeat (hold) @(posedge clk);
      #1;
      held = observe();
      chk({tag, "_hold_out"}, held, e);
      chk({tag, "_hold_hs"}, (DW+5)'({out_valid, in_ready}), (DW+5)'(2'b10));
      @(negedge clk);
      in_valid = 1'b0;
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_release"}, (DW+5)'({out_valid, in_ready}), (DW+5)'(2'b01));
  endtask

  initial begin
    exp_t zero_e;
    int   seen;
    logic [3:0] ropc;
    zero_e = '0;

    #12;
    chk("reset_out", observe(), zero_e);
    chk("reset_hs", (DW+5)'({out_valid, in_ready}), (DW+5)'(2'b01));
    @(negedge clk);
    rst_n = 1'b1;

    run_op("add_carry32", 4'h0, 128'hFFFF_FFFF, 128'h1, 1'b0, 0);
    chk("add_carry32_res", (DW+5)'(last_obs.res), (DW+5)'(128'h1_0000_0000));
    run_op("add_wrap", 4'h0, '1, 128'h1, 1'b0, 0);
    chk("add_wrap_flags", (DW+5)'({last_obs.res, last_obs.c, last_obs.z}), (DW+5)'(130'b11));
    run_op("sub_ovf", 4'h3, {1'b0, {(DW-1){1'b1}}}, '1, 1'b0, 0);
    chk("sub_ovf_flags", (DW+5)'({last_obs.o, last_obs.s, last_obs.c}), (DW+5)'(3'b110));
    run_op("subwb", 4'h1, 128'd5, 128'd3, 1'b0, 0);
    chk("subwb_res", (DW+5)'({last_obs.res, last_obs.c}), (DW+5)'({128'd1, 1'b1}));
    run_op("shl", 4'hD, {1'b1, {(DW-2){1'b0}}, 1'b1}, '0, 1'b0, 0);
    chk("shl_res", (DW+5)'({last_obs.res, last_obs.c, last_obs.o}), (DW+5)'({128'h2, 2'b11}));
    run_op("illegal_c", 4'hC, '1, '1, 1'b1, 0);
    chk("illegal_c_flags", (DW+5)'({last_obs.z, last_obs.ill}), (DW+5)'(2'b11));
`ifdef ALU_ROTATE_EN
    run_op("rol", 4'hE, {1'b1, {(DW-2){1'b0}}, 1'b1}, '0, 1'b0, 0);
    chk("rol_res", (DW+5)'({last_obs.res, last_obs.c, last_obs.ill}), (DW+5)'({128'h3, 2'b10}));
`else
    run_op("rol_off", 4'hE, {1'b1, {(DW-2){1'b0}}, 1'b1}, '0, 1'b0, 0);
`endif

    run_op("bp_hold", 4'h6, rnd_word(), rnd_word(), 1'b0, 6);
    run_op("bp_b2b", 4'hA, rnd_word(), rnd_word(), 1'b0, 0);

    // Reset in the middle of BUSY.
    @(negedge clk);
    in_valid = 1'b1; {mode, opsel} = 4'h0; op1 = '1; op2 = '1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("midbusy_rst_out", observe(), zero_e);
    chk("midbusy_rst_hs", (DW+5)'({out_valid, in_ready}), (DW+5)'(2'b01));
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("midbusy_no_valid", (DW+5)'(seen), (DW+5)'(0));

    for (int i = 0; i < 40; i++) begin
      ropc = 4'($urandom);
      run_op("rand", ropc, rnd_word(), rnd_word(), 1'($urandom), (i % 7 == 0) ? 3 : 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_slice_seq.md
Name: alu_slice_seq

Overview:
- Parametrised, serialised successor to the 128-bit combinational ALU; same opcode map and c/z/o/s flags.
- Processes a DWIDTH-bit operation as DWIDTH/SLICE narrow slices, one slice per clock, LSB slice first, carry chained between slices.
- Valid/ready handshakes on input and output, so it drops into a pipelined datapath.
- Trades latency for a SLICE-wide adder.

Parameters:
- DWIDTH, 128, operand/result width.
- SLICE, 32, bits processed per cycle. DWIDTH must be an integer multiple of SLICE. N = DWIDTH/SLICE.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept a request.
- opsel  in  3  operation select.
- mode  in  1  0 = arithmetic, 1 = logic; {mode,opsel} forms the 4-bit opcode.
- op1  in  DWIDTH  operand 1.
- op2  in  DWIDTH  operand 2.
- carry_in  in  1  carry for subwb, sampled at accept.
- out_valid  out  1  result/flags valid.
- out_ready  in  1  consumer accepts result.
- result  out  DWIDTH  result.
- c_flag, z_flag, o_flag, s_flag  out  1 each  carry, zero, signed overflow, sign.
- illegal  out  1  opcode was unassigned; valid with out_valid.

Behaviour:
- Opcodes (A=op1, B=op2). All arithmetic is computed as A + X + cin.
  - 0 add: A+B.
  - 1 subwb: A+~B+carry_in.
  - 2 mov: A.
  - 3 sub: A+~B+1.
  - 4 inc: A+1.
  - 5 dec: A+all-ones.
  - 6 addinc: A+B+1.
  - 8 and, 9 or, A xor: bitwise with B.
  - B not: ~A.
  - D shl: A<<1, LSB=0.
  - 7, C, E, F: illegal.
- Flags:
  - c_flag = carry out of bit DWIDTH-1. For sub/subwb, 1 means no borrow. For shl, c_flag = A[MSB].
  - z_flag = result==0, accumulated across slices.
  - s_flag = result[MSB].
  - o_flag: arithmetic ops use a two's-complement overflow test on the top slice; shl gives A[MSB]^A[MSB-1]; mov and logic ops give 0.
- Illegal opcode: result=0, z=1, c=o=s=0, illegal=1. It still takes N cycles.
- FSM states IDLE, BUSY, DONE.
  - IDLE: in_ready=1. in_valid&&in_ready registers op1, op2, opcode and carry_in, clears the slice index, then goes to BUSY.
  - BUSY: each cycle computes slice k, writes it into result[k*SLICE +: SLICE], and registers the carry or shifted-out bit for slice k+1. After slice N-1, flags are registered and the FSM goes to DONE.
  - DONE: out_valid=1. result and flags are held stable until out_valid&&out_ready, then the FSM returns to IDLE.
- Latency: out_valid rises on the Nth rising edge after the accept edge. in_ready returns 1 the cycle after the output handshake.
- Throughput: one operation per N+2 cycles. in_ready=0 in BUSY and DONE.
- result and flags change only in BUSY. They are never visible as partial values while out_valid=1.
- Reset, including assertion mid-BUSY or mid-DONE:
  - FSM goes to IDLE; in_ready=1.
  - out_valid=0, result=0, all flags=0, illegal=0.
  - Any in-flight operation is discarded.
- Inputs are ignored while not in IDLE; operand changes during BUSY have no effect.
- Degenerate N=1 (SLICE=DWIDTH) is legal and gives latency 1.

Optional Feature:
- Macro ALU_ROTATE_EN.
- Defined: opcode E = rol, A rotated left by 1. The captured A[MSB] feeds the LSB of slice 0, c_flag = A[MSB], o_flag = A[MSB]^A[MSB-1], illegal=0.
- Undefined: opcode E is illegal, as described in Behaviour.

Test Plan (DWIDTH=128, SLICE=32):
- add, op1=0xFFFFFFFF, op2=1 -> result=0x1_0000_0000, c=0, z=0, o=0, s=0. out_valid exactly 4 edges after accept. in_ready=0 throughout.
- add, op1=all-ones, op2=1 -> result=0, c=1, z=1, o=0, s=0. This checks carry propagating through all four slices.
- sub, op1=0x7FFF…FFFF, op2=all-ones (-1) -> result=0x8000…0000, o=1, s=1, c=0. Also subwb, op1=5, op2=3, carry_in=0 -> result=1, c=1.
- shl, op1=0x8000…0001 -> result=0x…0002, c=1, z=0, o=1. Also opcode 0xC -> result=0, z=1, illegal=1.
- Backpressure: hold out_ready=0 for 6 cycles in DONE -> result and flags stable, in_ready=0, and a new in_valid is ignored. Raise out_ready -> IDLE next cycle, then a back-to-back request is accepted.
- Reset pulse after 2 BUSY cycles -> all outputs 0 and in_ready=1 asynchronously, and no out_valid follows. With ALU_ROTATE_EN defined: rol, op1=0x8000…0001 -> result=0x…0003, c=1, illegal=0.
